mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit beside the EX stage of the pipelined MIPS core.
//   Executes MULT/MULTU/DIV/DIVU over WIDTH cycles, owns the HI/LO registers and accepts MTHI/MTLO writes.
//   Drives busy_o so the hazard unit can stall IF/ID while an operation runs.
//   Fixed latency per WIDTH, independent of operand values.
// PARAMETERS
//   WIDTH      32  operand and HI/LO width in bits (>=4)
//   SIGNED_EN  1   1: ops 00/10 are signed; 0: every op treated as unsigned
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   start_i    in   1      issue operation (sampled only in IDLE)
//   op_i       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i        in   WIDTH  rs operand (multiplicand / dividend)
//   b_i        in   WIDTH  rt operand (multiplier / divisor)
//   flush_i    in   1      abort running operation (branch/exception flush)
//   wr_hi_i    in   1      MTHI write strobe
//   wr_lo_i    in   1      MTLO write strobe
//   wr_data_i  in   WIDTH  MTHI/MTLO data
//   busy_o     out  1      operation in progress; hazard unit stalls on it
//   done_o     out  1      one-cycle pulse: HI/LO just updated
//   hi_o       out  WIDTH  HI register (product high half / remainder)
//   lo_o       out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, counter=0; any op discarded.
//   FSM IDLE -> RUN -> FIX -> IDLE.
//    IDLE: start_i=1 at edge E0 latches |a|,|b| (signed ops), result signs, op; busy_o=1 from E0.
//    RUN: one radix-2 step per cycle (shift-add mult, restoring div), WIDTH steps, edges E1..E_WIDTH.
//    FIX: at edge E_WIDTH+1 apply sign correction, write hi_o/lo_o, done_o=1, busy_o=0, go IDLE.
//   Latency: results visible WIDTH+1 edges after start edge; done_o high exactly one cycle.
//   Mult: {hi,lo} = full 2*WIDTH-bit product. Div: lo=quotient, hi=remainder (sign of dividend, trunc toward 0).
//   Divide by zero: no trap; fixed latency; lo=all ones, hi=a_i (unsigned and signed alike).
//   Signed overflow (MIN / -1): lo=MIN, hi=0.
//   start_i while busy_o=1: ignored, no queueing.
//   flush_i=1 in RUN or FIX: next edge -> IDLE, busy_o=0, no done_o, hi/lo unchanged. flush_i in IDLE: no effect;
//    flush_i and start_i same cycle in IDLE: start ignored.
//   wr_hi_i/wr_lo_i in IDLE: register written at edge; with start_i same cycle write happens, op still accepted.
//   wr_hi_i/wr_lo_i while busy_o=1: ignored (hazard unit guarantees no MTHI/MTLO issue then).
//   hi_o/lo_o hold value between updates; reads during busy return pre-op values.
// TESTING (WIDTH=32, latency 33 edges)
//   MULT a=0xFFFFFFFD (-3), b=7 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, done_o one cycle.
//   MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy_o high exactly 33 cycles.
//   DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after 33 edges.
//   MTLO 0x55 in IDLE, then MULTU 3*4 with flush_i at cycle 10 -> busy_o low next edge, lo=0x55, no done_o.
//   rst_n low at cycle 20 of DIVU -> hi=lo=0, busy_o=0 immediately; start_i mid-op -> ignored, result unaffected.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit beside the EX stage; owns HI/LO and serves MTHI/MTLO.
// Every operation takes WIDTH+1 cycles from the start edge to the HI/LO update.
module mips_muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } stateT;

  stateT state, nextState;

  logic [CW-1:0]      stepCount;
  logic [WIDTH-1:0]   workHi, workLo, opReg, aRaw;
  logic               isDiv, negLo, negHi, divZero;
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               signedOp, aNeg, bNeg, startAccept;
  logic [WIDTH-1:0]   aAbs, bAbs;
  logic [WIDTH:0]     mulSum, divShift, divTrial;
  logic               divOk;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   fixHi, fixLo;

  // Operand conditioning: magnitudes and sign flags captured at the start edge
  always_comb begin
    signedOp    = SIGNED_EN && !op_i[0];
    aNeg        = signedOp && a_i[WIDTH-1];
    bNeg        = signedOp && b_i[WIDTH-1];
    aAbs        = aNeg ? -a_i : a_i;
    bAbs        = bNeg ? -b_i : b_i;
    startAccept = (state == IDLE) && start_i && !flush_i;
  end

  // One radix-2 step: shift-add multiply or restoring-divide trial subtraction
  always_comb begin
    mulSum   = {1'b0, workHi} + (workLo[0] ? {1'b0, opReg} : '0);
    divShift = {workHi, workLo[WIDTH-1]};
    divTrial = divShift - {1'b0, opReg};
    divOk    = !divTrial[WIDTH];
  end

  // Sign correction; divide by zero bypasses the iterated result entirely
  always_comb begin
    product = {workHi, workLo};
    fixHi   = workHi;
    fixLo   = workLo;
    if (!isDiv) begin
      if (negLo) product = -product;
      fixHi = product[2*WIDTH-1:WIDTH];
      fixLo = product[WIDTH-1:0];
    end else if (divZero) begin
      fixHi = aRaw;
      fixLo = '1;
    end else begin
      fixHi = negHi ? -workHi : workHi;
      fixLo = negLo ? -workLo : workLo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (startAccept) nextState = RUN;
      RUN: begin
        if (flush_i)                             nextState = IDLE;
        else if (stepCount == CW'(WIDTH - 1))    nextState = FIX;
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Working datapath plus architectural HI/LO, which only change on MTHI/MTLO or FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stepCount <= '0;
      workHi    <= '0;
      workLo    <= '0;
      opReg     <= '0;
      aRaw      <= '0;
      isDiv     <= 1'b0;
      negLo     <= 1'b0;
      negHi     <= 1'b0;
      divZero   <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
      done_o    <= 1'b0;
    end else begin
      done_o <= (state == FIX) && !flush_i;
      case (state)
        IDLE: begin
          if (wr_hi_i) hiReg <= wr_data_i;
          if (wr_lo_i) loReg <= wr_data_i;
          if (startAccept) begin
            stepCount <= '0;
            workHi    <= '0;
            workLo    <= op_i[1] ? aAbs : bAbs;
            opReg     <= op_i[1] ? bAbs : aAbs;
            aRaw      <= a_i;
            isDiv     <= op_i[1];
            negLo     <= aNeg ^ bNeg;
            negHi     <= aNeg;
            divZero   <= op_i[1] && (b_i == '0);
          end
        end
        RUN: begin
          if (!flush_i) begin
            stepCount <= stepCount + 1'b1;
            if (isDiv) begin
              workHi <= divOk ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
              workLo <= {workLo[WIDTH-2:0], divOk};
            end else begin
              {workHi, workLo} <= {mulSum, workLo[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!flush_i) begin
            hiReg <= fixHi;
            loReg <= fixLo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign hi_o   = hiReg;
  assign lo_o   = loReg;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32): expected HI/LO are queued at issue
// and popped by a monitor whenever done_o is seen.
module tb_mips_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        wr_hi_i, wr_lo_i;
  logic [31:0] wr_data_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } sbEntry;

  sbEntry sb[$];
  sbEntry expVal;
  int     tests = 0;
  int     fails = 0;

  mips_muldiv_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .flush_i   (flush_i),
    .wr_hi_i   (wr_hi_i),
    .wr_lo_i   (wr_lo_i),
    .wr_data_i (wr_data_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedDone: done_o=1 with no pending operation, hi=0x%08h lo=0x%08h",
                 hi_o, lo_o);
      end else begin
        expVal = sb.pop_front();
        checkOutput({expVal.name, ".hi"}, hi_o, expVal.hi);
        checkOutput({expVal.name, ".lo"}, lo_o, expVal.lo);
      end
    end
  end

  // mode 0: plain op; 1: stray start_i mid-op; 2: MTHI 0x77 together with start
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int mode);
    int busyCount;
    int doneAt;
    sb.push_back('{name, expHi, expLo});
    @(posedge clk);
    #1;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    if (mode == 2) begin
      wr_hi_i   = 1'b1;
      wr_data_i = 32'h77;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wr_hi_i = 1'b0;
    busyCount = 0;
    doneAt    = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mode == 1 && k == 5) begin
        start_i = 1'b1;
        op_i    = 2'b00;
        a_i     = 32'd3;
        b_i     = 32'd3;
      end
      if (mode == 1 && k == 6) start_i = 1'b0;
      if (mode == 2 && k == 3) checkOutput({name, ".hiDuringBusy"}, hi_o, 32'h77);
      if (busy_o) busyCount++;
      if (done_o) begin
        doneAt = k;
        break;
      end
    end
    checkOutput({name, ".latency"}, doneAt, 32'd33);
    checkOutput({name, ".busyCycles"}, busyCount, 32'd33);
    @(negedge clk);
    checkOutput({name, ".donePulse"}, {31'b0, done_o}, 32'd0);
    checkOutput({name, ".idleAfter"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    op_i      = 2'b00;
    a_i       = '0;
    b_i       = '0;
    flush_i   = 1'b0;
    wr_hi_i   = 1'b0;
    wr_lo_i   = 1'b0;
    wr_data_i = '0;

    @(negedge clk);
    checkOutput("reset.hi", hi_o, 32'h0);
    checkOutput("reset.lo", lo_o, 32'h0);
    checkOutput("reset.busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset.done", {31'b0, done_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("multNeg3x7",    2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    applyStimulus("multuMax",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    applyStimulus("divNeg7by2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    applyStimulus("divOverflow",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    applyStimulus("divuByZero",    2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 0);
    applyStimulus("divByZeroNeg",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    applyStimulus("div7byNeg2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    applyStimulus("multMixedSign", 2'b00, 32'h00010000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFE0000, 0);
    applyStimulus("multuWithMthi", 2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 2);

    // start_i together with flush_i in IDLE must not launch an operation
    @(negedge clk);
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 2'b01;
    a_i     = 32'd5;
    b_i     = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    checkOutput("startWithFlushIgnored", {31'b0, busy_o}, 32'd0);

    @(negedge clk);
    wr_hi_i   = 1'b1;
    wr_data_i = 32'hAAAA;
    @(negedge clk);
    wr_hi_i   = 1'b0;
    wr_lo_i   = 1'b1;
    wr_data_i = 32'h55;
    @(negedge clk);
    wr_lo_i = 1'b0;
    checkOutput("mthi", hi_o, 32'hAAAA);
    checkOutput("mtlo", lo_o, 32'h55);

    start_i = 1'b1;
    op_i    = 2'b01;
    a_i     = 32'd3;
    b_i     = 32'd4;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush.busy", {31'b0, busy_o}, 32'd0);
    checkOutput("flush.lo", lo_o, 32'h55);
    checkOutput("flush.hi", hi_o, 32'hAAAA);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) doneSeen = 1;
    end
    checkOutput("flush.noDone", doneSeen, 32'd0);

    // Asynchronous reset in the middle of a DIVU clears everything immediately
    start_i = 1'b1;
    op_i    = 2'b11;
    a_i     = 32'd1000;
    b_i     = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.hi", hi_o, 32'h0);
    checkOutput("midReset.lo", lo_o, 32'h0);
    checkOutput("midReset.busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("divu100by7StrayStart", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboardDrained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
